// File: rtl/cpu_pkg.sv
// Shared definitions for the simplified RISC CPU: widths, phase encoding, opcodes.
package cpu_pkg;

  localparam int CPU_ADDR_W = 13;
  localparam int CPU_DATA_W = 8;
  localparam int CPU_OPC_W  = 3;

  // Instruction phase encoding (4-bit binary)
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_P0   = 4'd1;
  localparam logic [3:0] ST_P1   = 4'd2;
  localparam logic [3:0] ST_P2   = 4'd3;
  localparam logic [3:0] ST_P3   = 4'd4;
  localparam logic [3:0] ST_P4   = 4'd5;
  localparam logic [3:0] ST_P5   = 4'd6;
  localparam logic [3:0] ST_P6   = 4'd7;
  localparam logic [3:0] ST_P7   = 4'd8;
  localparam logic [3:0] ST_HALT = 4'd9;

  // Opcodes carried in IR[15:13]
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

endpackage

// File: rtl/fetch_seq_if.sv
// Fetch-stage bus: ROM byte and controller requests in, strobes and addresses out.
interface fetch_seq_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int OPC_W  = 3
);
  logic              ena;
  logic [DATA_W-1:0] data_in;
  logic              jmp;
  logic              skip;
  logic              hlt;
  logic              fetch;
  logic              alu_ena;
  logic [ADDR_W-1:0] pc_addr;
  logic [ADDR_W-1:0] ir_addr;
  logic [OPC_W-1:0]  opcode;
  logic              instr_valid;
  logic              halted;

  // The fetch sequencer side
  modport master (
    input  ena, data_in, jmp, skip, hlt,
    output fetch, alu_ena, pc_addr, ir_addr, opcode, instr_valid, halted
  );

  // The surrounding CPU (address mux, controller, ROM) side
  modport slave (
    output ena, data_in, jmp, skip, hlt,
    input  fetch, alu_ena, pc_addr, ir_addr, opcode, instr_valid, halted
  );
endinterface

// File: rtl/fetch_pc.sv
// Program counter: load beats +2 beats +1; all arithmetic wraps modulo 2^ADDR_W.
module fetch_pc #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              inc1,
  input  logic              inc2,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  // PC register, frozen whenever ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (ena) begin
      if (load)      pc <= load_val;
      else if (inc2) pc <= pc + ADDR_W'(2);
      else if (inc1) pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: 8-phase instruction cycle, IR assembly from two ROM bytes,
// and PC control. All outputs decode from registered state only.
module fetch_seq
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int OPC_W  = CPU_OPC_W
) (
  input  logic       clk,
  input  logic       rst_n,
  fetch_seq_if.master bus
);

  logic [3:0]          state;
  logic [3:0]          state_nxt;
  logic [2*DATA_W-1:0] ir;
  logic [ADDR_W-1:0]   pc;
  logic                in_p7;
  logic                pc_inc1;
  logic                pc_inc2;
  logic                pc_load;

  // Next-phase decode; HALT is only left through reset
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_P0;
      ST_P0, ST_P1, ST_P2, ST_P3, ST_P4, ST_P5, ST_P6:
               state_nxt = state + 4'd1;
      ST_P7:   state_nxt = bus.hlt ? ST_HALT : ST_P0;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state <= ST_IDLE;
    else if (bus.ena) state <= state_nxt;
  end

  // Instruction register: high byte captured leaving P1, low byte leaving P3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (bus.ena) begin
      if (state == ST_P1)      ir[2*DATA_W-1:DATA_W] <= bus.data_in;
      else if (state == ST_P3) ir[DATA_W-1:0]        <= bus.data_in;
    end
  end

  // Controller requests only count at the P7 edge; jmp has priority over skip
  assign in_p7   = (state == ST_P7);
  assign pc_inc1 = (state == ST_P1) || (state == ST_P3);
  assign pc_load = in_p7 && bus.jmp;
  assign pc_inc2 = in_p7 && bus.skip && !bus.jmp;

  fetch_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (bus.ena),
    .inc1     (pc_inc1),
    .inc2     (pc_inc2),
    .load     (pc_load),
    .load_val (ir[ADDR_W-1:0]),
    .pc       (pc)
  );

  assign bus.fetch       = state inside {ST_P0, ST_P1, ST_P2, ST_P3};
  assign bus.alu_ena     = (state == ST_P4);
  assign bus.instr_valid = state inside {ST_P4, ST_P5, ST_P6, ST_P7};
  assign bus.halted      = (state == ST_HALT);
  assign bus.pc_addr     = pc;
  assign bus.ir_addr     = ir[ADDR_W-1:0];
  assign bus.opcode      = ir[2*DATA_W-1 -: OPC_W];

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: a small ROM program drives the sequencer through
// jumps, skips, PC wrap, an ena stall, halt and an asynchronous reset.
module tb_fetch_seq;

  logic clk;
  logic rst_n;

  fetch_seq_if #(.ADDR_W(13), .DATA_W(8), .OPC_W(3)) bus ();

  fetch_seq #(.ADDR_W(13), .DATA_W(8), .OPC_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rom [0:8191];
  assign bus.data_in = rom[bus.pc_addr];

  int tests_run = 0;
  int tests_failed = 0;

  // {opcode, ir_addr, pc_addr} expected while alu_ena is high
  logic [28:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " fetch"},       32'(bus.fetch),       32'd0);
    chk({tag, " alu_ena"},     32'(bus.alu_ena),     32'd0);
    chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, " halted"},      32'(bus.halted),      32'd0);
    chk({tag, " pc_addr"},     32'(bus.pc_addr),     32'd0);
    chk({tag, " ir_addr"},     32'(bus.ir_addr),     32'd0);
    chk({tag, " opcode"},      32'(bus.opcode),      32'd0);
  endtask

  // Monitor: every alu_ena cycle must match the next queued instruction
  always @(negedge clk) begin
    if (rst_n && bus.alu_ena) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL alu_ena: unexpected pulse, opcode=0x%0h ir_addr=0x%0h required none",
                 bus.opcode, bus.ir_addr);
      end else begin
        logic [28:0] e;
        e = exp_q.pop_front();
        chk("P4 opcode",  32'(bus.opcode),  32'(e[28:26]));
        chk("P4 ir_addr", 32'(bus.ir_addr), 32'(e[25:13]));
        chk("P4 pc_addr", 32'(bus.pc_addr), 32'(e[12:0]));
      end
    end
  end

  // Runs one instruction starting just after the edge into P0.
  // noise drives jmp/skip/hlt high in P0..P6 to show they are ignored there.
  task automatic run_instr(input logic [2:0] eo, input logic [12:0] ea, input logic [12:0] ep,
                           input logic j, input logic s, input logic h, input logic noise,
                           input int hold, input logic [12:0] hold_pc,
                           input logic [2:0] hold_opc, input logic [12:0] hold_addr);
    exp_q.push_back({eo, ea, ep});
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("P%0d fetch", k), 32'(bus.fetch), 32'(k < 4));
      chk($sformatf("P%0d instr_valid", k), 32'(bus.instr_valid), 32'(k >= 4));
      if (k == 2 && hold > 0) begin
        bus.ena = 1'b0;
        for (int c = 0; c < hold; c++) begin
          @(posedge clk); #1;
          chk("stall fetch",   32'(bus.fetch),   32'd1);
          chk("stall pc_addr", 32'(bus.pc_addr), 32'(hold_pc));
          chk("stall opcode",  32'(bus.opcode),  32'(hold_opc));
          chk("stall ir_addr", 32'(bus.ir_addr), 32'(hold_addr));
        end
        bus.ena = 1'b1;
      end
      if (k == 7) begin
        bus.jmp = j; bus.skip = s; bus.hlt = h;
      end else begin
        bus.jmp = noise; bus.skip = noise; bus.hlt = noise;
      end
      @(posedge clk); #1;
    end
    bus.jmp = 1'b0; bus.skip = 1'b0; bus.hlt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 8'h00;
    rom[13'h0000] = 8'hA1; rom[13'h0001] = 8'h23;   // LDA 0x0123
    rom[13'h0002] = 8'hE4; rom[13'h0003] = 8'h56;   // JMP 0x0456
    rom[13'h0456] = 8'hE0; rom[13'h0457] = 8'h0E;   // JMP 0x000E
    rom[13'h000E] = 8'h20; rom[13'h000F] = 8'h00;   // SKZ
    rom[13'h0012] = 8'hFF; rom[13'h0013] = 8'hFE;   // JMP 0x1FFE
    rom[13'h1FFE] = 8'h40; rom[13'h1FFF] = 8'h77;   // ADD 0x0077

    rst_n = 1'b0;
    bus.ena = 1'b1; bus.jmp = 1'b0; bus.skip = 1'b0; bus.hlt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("IDLE fetch", 32'(bus.fetch), 32'd0);
    @(posedge clk); #1;

    run_instr(3'd5, 13'h0123, 13'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 0, 13'h0, 3'd0, 13'h0);
    run_instr(3'd7, 13'h0456, 13'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 0, 13'h0, 3'd0, 13'h0);
    chk("jmp priority pc", 32'(bus.pc_addr), 32'h0456);
    run_instr(3'd7, 13'h000E, 13'h0458, 1'b1, 1'b0, 1'b0, 1'b0, 0, 13'h0, 3'd0, 13'h0);
    chk("jmp pc", 32'(bus.pc_addr), 32'h000E);
    run_instr(3'd1, 13'h0000, 13'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 0, 13'h0, 3'd0, 13'h0);
    chk("skip pc", 32'(bus.pc_addr), 32'h0012);
    run_instr(3'd7, 13'h1FFE, 13'h0014, 1'b1, 1'b0, 1'b0, 1'b0, 0, 13'h0, 3'd0, 13'h0);
    chk("jmp 1FFE pc", 32'(bus.pc_addr), 32'h1FFE);
    run_instr(3'd2, 13'h0077, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5, 13'h1FFF, 3'd2, 13'h00FE);
    chk("no-op P7 pc", 32'(bus.pc_addr), 32'h0000);
    run_instr(3'd5, 13'h0123, 13'h0002, 1'b0, 1'b1, 1'b1, 1'b0, 0, 13'h0, 3'd0, 13'h0);

    chk("HALT halted",      32'(bus.halted),      32'd1);
    chk("HALT fetch",       32'(bus.fetch),       32'd0);
    chk("HALT instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("HALT pc_addr",     32'(bus.pc_addr),     32'h0004);
    repeat (6) @(posedge clk);
    #1;
    chk("HALT held halted", 32'(bus.halted),  32'd1);
    chk("HALT held fetch",  32'(bus.fetch),   32'd0);
    chk("HALT held pc",     32'(bus.pc_addr), 32'h0004);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset from HALT");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart P0 fetch", 32'(bus.fetch), 32'd1);
    exp_q.push_back({3'd5, 13'h0123, 13'h0002});
    repeat (5) @(posedge clk);
    #3;
    chk("P5 instr_valid", 32'(bus.instr_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset P5");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr(3'd5, 13'h0123, 13'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 0, 13'h0, 3'd0, 13'h0);
    chk("restart pc after instr", 32'(bus.pc_addr), 32'h0002);

    chk("pending expectations", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
